diff_out_arbiter: RTL and testbench

//   Shares one differential tristate output pair (OBUFTDS I/T pins) among N_REQ requesters.

---
 rtl/diff_out_arbiter_if.sv | 36 +++
 rtl/diff_out_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_diff_out_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/diff_out_arbiter_if.sv
// diff_out_arbiter_if: requester/pad-side bundle of the shared differential output arbiter.
//   req     N_REQ  level request per requester
//   data    N_REQ  data bit per requester
//   gnt     N_REQ  one-hot grant (registered in the arbiter)
//   obuf_i  1      to OBUFTDS I
//   obuf_t  1      to OBUFTDS T (1 = high-Z)
//   busy    1      arbiter is driving or in turnaround
// Modports: master = user logic side, slave = arbiter side.
interface diff_out_arbiter_if #(
    parameter int unsigned N_REQ = 2
);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] data;
    logic [N_REQ-1:0] gnt;
    logic             obuf_i;
    logic             obuf_t;
    logic             busy;

    modport master (
        output req,
        output data,
        input  gnt,
        input  obuf_i,
        input  obuf_t,
        input  busy
    );

    modport slave (
        input  req,
        input  data,
        output gnt,
        output obuf_i,
        output obuf_t,
        output busy
    );
endinterface

// File: rtl/diff_out_arbiter.sv
// diff_out_arbiter: shares one differential tristate pair (OBUFTDS I/T) among N_REQ
// requesters with round-robin arbitration and a high-Z turnaround gap between owners.
// All outputs are registered; the OBUFTDS primitive lives outside this block.
// Ports:
//   clk  in   system clock, all logic on posedge
//   rst  in   synchronous reset, active-high
//   bus  slave modport of diff_out_arbiter_if (req, data in; gnt, obuf_i, obuf_t, busy out)
// Parameters:
//   N_REQ       number of requesters (>= 2)
//   TURNAROUND  high-Z cycles after each release (>= 0)
//   MAX_HOLD    max drive cycles per grant, only with DIFF_OUT_ARB_TIMEOUT_EN (>= 1)
// Configuration macro:
//   DIFF_OUT_ARB_TIMEOUT_EN  when defined, a grant is force-released after MAX_HOLD cycles.
module diff_out_arbiter #(
    parameter int unsigned N_REQ      = 2,
    parameter int unsigned TURNAROUND = 2,
    parameter int unsigned MAX_HOLD   = 16
) (
    input logic                clk,
    input logic                rst,
    diff_out_arbiter_if.slave  bus
);

    localparam int unsigned IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned TCNT_W = (TURNAROUND > 1) ? $clog2(TURNAROUND + 1) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StTurn
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [TCNT_W-1:0]  tcnt_q, tcnt_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic               obuf_t_q, obuf_t_d;
    logic               obuf_i_q, obuf_i_d;
    logic               busy_q, busy_d;

    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   cand;
    logic [IDX_W-1:0]   next_ptr;
    logic               release_now;

`ifdef DIFF_OUT_ARB_TIMEOUT_EN
    localparam int unsigned HCNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;
    logic [HCNT_W-1:0]  hcnt_q, hcnt_d;

    // Hold limit reached counts as a release even while req stays high.
    assign release_now = !bus.req[owner_q] || (hcnt_q == HCNT_W'(MAX_HOLD));
`else
    logic unused_cfg;
    assign unused_cfg  = ^MAX_HOLD;
    assign release_now = !bus.req[owner_q];
`endif

    // Round-robin search: first high request starting at ptr, wrapping modulo N_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            cand = IDX_W'((int'(ptr_q) + i) % int'(N_REQ));
            if (!win_found && bus.req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign next_ptr = IDX_W'((int'(owner_q) + 1) % int'(N_REQ));

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        tcnt_d   = tcnt_q;
        gnt_d    = gnt_q;
        obuf_t_d = obuf_t_q;
        obuf_i_d = obuf_i_q;
        busy_d   = busy_q;
`ifdef DIFF_OUT_ARB_TIMEOUT_EN
        hcnt_d   = hcnt_q;
`endif

        unique case (state_q)
            StIdle: begin
                gnt_d    = '0;
                obuf_t_d = 1'b1;
                obuf_i_d = 1'b0;
                busy_d   = 1'b0;
                if (win_found) begin
                    state_d          = StDrive;
                    owner_d          = win_idx;
                    gnt_d[win_idx]   = 1'b1;
                    obuf_t_d         = 1'b0;
                    obuf_i_d         = bus.data[win_idx];
                    busy_d           = 1'b1;
`ifdef DIFF_OUT_ARB_TIMEOUT_EN
                    hcnt_d           = HCNT_W'(1);
`endif
                end
            end

            StDrive: begin
                if (release_now) begin
                    gnt_d    = '0;
                    obuf_t_d = 1'b1;
                    obuf_i_d = 1'b0;
                    ptr_d    = next_ptr;
                    if (TURNAROUND == 0) begin
                        state_d = StIdle;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = StTurn;
                        tcnt_d  = TCNT_W'(TURNAROUND);
                        busy_d  = 1'b1;
                    end
                end else begin
                    // Pad follows the owner's data with one cycle of latency.
                    obuf_i_d = bus.data[owner_q];
`ifdef DIFF_OUT_ARB_TIMEOUT_EN
                    hcnt_d   = hcnt_q + HCNT_W'(1);
`endif
                end
            end

            StTurn: begin
                gnt_d    = '0;
                obuf_t_d = 1'b1;
                obuf_i_d = 1'b0;
                busy_d   = 1'b1;
                // Requests are ignored here; the IDLE cycle that follows is part of the gap.
                if (tcnt_q <= TCNT_W'(1)) begin
                    state_d = StIdle;
                    tcnt_d  = '0;
                    busy_d  = 1'b0;
                end else begin
                    tcnt_d = tcnt_q - TCNT_W'(1);
                end
            end

            default: begin
                state_d  = StIdle;
                gnt_d    = '0;
                obuf_t_d = 1'b1;
                obuf_i_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            owner_q  <= '0;
            ptr_q    <= '0;
            tcnt_q   <= '0;
            gnt_q    <= '0;
            obuf_t_q <= 1'b1;
            obuf_i_q <= 1'b0;
            busy_q   <= 1'b0;
`ifdef DIFF_OUT_ARB_TIMEOUT_EN
            hcnt_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            tcnt_q   <= tcnt_d;
            gnt_q    <= gnt_d;
            obuf_t_q <= obuf_t_d;
            obuf_i_q <= obuf_i_d;
            busy_q   <= busy_d;
`ifdef DIFF_OUT_ARB_TIMEOUT_EN
            hcnt_q   <= hcnt_d;
`endif
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.obuf_t = obuf_t_q;
    assign bus.obuf_i = obuf_i_q;
    assign bus.busy   = busy_q;

endmodule

// File: tb/tb_diff_out_arbiter.sv
// tb_diff_out_arbiter: self-checking bench for diff_out_arbiter with an OBUFTDS pad model
// and a behavioural ownership/gap model of the arbitration rules.
module tb_diff_out_arbiter;

    localparam int N          = 2;
    localparam int TURNAROUND = 2;
    localparam int MAX_HOLD   = 4;
`ifdef DIFF_OUT_ARB_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    logic clk;
    logic rst;

    diff_out_arbiter_if #(.N_REQ(N)) bus ();

    diff_out_arbiter #(
        .N_REQ      (N),
        .TURNAROUND (TURNAROUND),
        .MAX_HOLD   (MAX_HOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // OBUFTDS model
    wire diff_p;
    wire diff_n;
    assign diff_p = bus.obuf_t ? 1'bz : bus.obuf_i;
    assign diff_n = bus.obuf_t ? 1'bz : ~bus.obuf_i;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the pair, how many high-Z turnaround cycles remain,
    // how long the owner has held it, and where the round-robin search starts.
    int         m_owner = -1;
    int         m_ptr   = 0;
    int         m_gap   = 0;
    int         m_held  = 0;
    logic [N-1:0] m_gnt = '0;
    logic       m_t     = 1'b1;
    logic       m_i     = 1'b0;
    logic       m_busy  = 1'b0;

    // Advance one clock; the model consumes the same inputs the DUT sampled.
    task automatic tick();
        int c;
        @(posedge clk);
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_gap = 0; m_held = 0;
            m_gnt = '0; m_t = 1'b1; m_i = 1'b0; m_busy = 1'b0;
        end else if (m_owner >= 0) begin
            if (!bus.req[m_owner] || (TIMEOUT_EN && m_held >= MAX_HOLD)) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_gap   = TURNAROUND;
                m_gnt   = '0;
                m_t     = 1'b1;
                m_i     = 1'b0;
                m_busy  = (m_gap > 0);
            end else begin
                m_held++;
                m_i = bus.data[m_owner];
            end
        end else if (m_gap > 0) begin
            m_gap--;
            m_busy = (m_gap > 0);
        end else begin
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (m_owner < 0 && bus.req[c]) m_owner = c;
            end
            if (m_owner >= 0) begin
                m_held         = 1;
                m_gnt          = '0;
                m_gnt[m_owner] = 1'b1;
                m_t            = 1'b0;
                m_i            = bus.data[m_owner];
                m_busy         = 1'b1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req = '0;
        bus.data = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({bus.gnt, bus.obuf_t, bus.obuf_i, bus.busy} !== {2'b00, 1'b1, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL reset: got gnt=%b t=%b i=%b busy=%b expected gnt=00 t=1 i=0 busy=0",
                         bus.gnt, bus.obuf_t, bus.obuf_i, bus.busy);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_single_drive();
        logic d_sent;
        rst = 1'b1; tick(); rst = 1'b0;
        bus.req = 2'b01;
        for (int k = 0; k < 12; k++) begin
            bus.data[0] = (k % 2 == 0);
            bus.data[1] = 1'($urandom);
            d_sent = bus.data[0];
            tick();
            checks++;
            if ({bus.gnt, bus.obuf_t} !== {2'b01, 1'b0}) begin
                errors++;
                $display("FAIL single_grant: got gnt=%b t=%b expected gnt=01 t=0",
                         bus.gnt, bus.obuf_t);
            end
            checks++;
            if (bus.obuf_i !== d_sent) begin
                errors++;
                $display("FAIL single_latency: got obuf_i=%b expected %b", bus.obuf_i, d_sent);
            end
            checks++;
            if (diff_p !== d_sent || diff_n !== ~d_sent) begin
                errors++;
                $display("FAIL single_pair: got p=%b n=%b expected p=%b n=%b",
                         diff_p, diff_n, d_sent, ~d_sent);
            end
        end
        bus.req = '0;
        for (int k = 0; k < 4; k++) begin
            bus.data = 2'($urandom);
            tick();
            checks++;
            if ({bus.gnt, bus.obuf_t, bus.obuf_i, bus.busy} !== {m_gnt, m_t, m_i, m_busy}) begin
                errors++;
                $display("FAIL single_release: got %b expected %b",
                         {bus.gnt, bus.obuf_t, bus.obuf_i, bus.busy}, {m_gnt, m_t, m_i, m_busy});
            end
        end
    endtask

    task automatic test_contention();
        int hz;
        bit got;
        rst = 1'b1; tick(); rst = 1'b0;
        bus.req = 2'b11;
        bus.data = 2'($urandom);
        tick();
        checks++;
        if (bus.gnt !== 2'b01) begin
            errors++;
            $display("FAIL contention_first: got gnt=%b expected 01", bus.gnt);
        end
        for (int k = 0; k < 3; k++) begin
            bus.data = 2'($urandom);
            tick();
        end
        bus.req = 2'b10;
        hz = 0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            bus.data = 2'($urandom);
            tick();
            checks++;
            if ({bus.gnt, bus.obuf_t, bus.obuf_i, bus.busy} !== {m_gnt, m_t, m_i, m_busy}) begin
                errors++;
                $display("FAIL contention_model: got %b expected %b",
                         {bus.gnt, bus.obuf_t, bus.obuf_i, bus.busy}, {m_gnt, m_t, m_i, m_busy});
            end
            if (bus.gnt === 2'b10) got = 1'b1;
            else if (bus.obuf_t === 1'b1) hz++;
        end
        checks++;
        if (!got || hz != TURNAROUND + 1) begin
            errors++;
            $display("FAIL contention_gap: got handover=%0d hz=%0d expected handover=1 hz=%0d",
                     got, hz, TURNAROUND + 1);
        end
        bus.req = '0;
        for (int k = 0; k < 5; k++) tick();
    endtask

    task automatic test_reset_mid_drive();
        rst = 1'b1; tick(); rst = 1'b0;
        bus.req = 2'b01;
        bus.data = 2'b11;
        tick();
        checks++;
        if ({bus.gnt, bus.obuf_t} !== {2'b01, 1'b0}) begin
            errors++;
            $display("FAIL midrst_grant: got gnt=%b t=%b expected gnt=01 t=0", bus.gnt, bus.obuf_t);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({bus.gnt, bus.obuf_t, bus.obuf_i, bus.busy} !== {2'b00, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL midrst_release: got gnt=%b t=%b i=%b busy=%b expected 00 1 0 0",
                     bus.gnt, bus.obuf_t, bus.obuf_i, bus.busy);
        end
        rst = 1'b0;
        bus.req = 2'b10;
        tick();
        checks++;
        if ({bus.gnt, bus.obuf_t, bus.obuf_i} !== {2'b10, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL midrst_regrant: got gnt=%b t=%b i=%b expected gnt=10 t=0 i=1",
                     bus.gnt, bus.obuf_t, bus.obuf_i);
        end
        bus.req = '0;
        for (int k = 0; k < 5; k++) tick();
    endtask

`ifdef DIFF_OUT_ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic [1:0] exp_gnt;
        int pos;
        rst = 1'b1;
        bus.req = 2'b11;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 18; k++) begin
            bus.data = 2'($urandom);
            tick();
            // MAX_HOLD drive cycles then TURNAROUND+1 high-Z cycles, owners alternating.
            pos = k % (MAX_HOLD + TURNAROUND + 1);
            if (pos < MAX_HOLD) exp_gnt = ((k / (MAX_HOLD + TURNAROUND + 1)) % 2 == 0) ? 2'b01 : 2'b10;
            else exp_gnt = 2'b00;
            checks++;
            if (bus.gnt !== exp_gnt || bus.obuf_t !== (exp_gnt == 2'b00)) begin
                errors++;
                $display("FAIL timeout_seq[%0d]: got gnt=%b t=%b expected gnt=%b t=%b",
                         k, bus.gnt, bus.obuf_t, exp_gnt, exp_gnt == 2'b00);
            end
        end
        bus.req = '0;
        for (int k = 0; k < 5; k++) tick();
    endtask
`else
    task automatic test_no_timeout();
        rst = 1'b1; tick(); rst = 1'b0;
        bus.req = 2'b01;
        for (int k = 0; k < 40; k++) begin
            bus.data = 2'($urandom);
            tick();
            checks++;
            if ({bus.gnt, bus.obuf_t} !== {2'b01, 1'b0}) begin
                errors++;
                $display("FAIL no_timeout[%0d]: got gnt=%b t=%b expected gnt=01 t=0",
                         k, bus.gnt, bus.obuf_t);
            end
        end
        bus.req = '0;
        for (int k = 0; k < 5; k++) tick();
    endtask
`endif

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            rst = ($urandom_range(49) == 0);
            if ($urandom_range(3) == 0) bus.req = 2'($urandom);
            bus.data = 2'($urandom);
            tick();
            checks++;
            if ({bus.gnt, bus.obuf_t, bus.obuf_i, bus.busy} !== {m_gnt, m_t, m_i, m_busy}) begin
                errors++;
                $display("FAIL random_model[%0d]: got gnt=%b t=%b i=%b busy=%b expected gnt=%b t=%b i=%b busy=%b",
                         k, bus.gnt, bus.obuf_t, bus.obuf_i, bus.busy, m_gnt, m_t, m_i, m_busy);
            end
            checks++;
            if (((bus.gnt & (bus.gnt - 2'b01)) != 2'b00) ||
                (bus.obuf_t === 1'b0 && bus.gnt === 2'b00) ||
                (bus.obuf_t === 1'b1 && bus.obuf_i !== 1'b0)) begin
                errors++;
                $display("FAIL random_invariant[%0d]: got gnt=%b t=%b i=%b expected onehot0, t=0 only with gnt, i=0 when t=1",
                         k, bus.gnt, bus.obuf_t, bus.obuf_i);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.req = '0;
        bus.data = '0;
        test_reset();
        test_single_drive();
        test_contention();
        test_reset_mid_drive();
`ifdef DIFF_OUT_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
